// File: rtl/sap_pkg.sv
// rtl/sap_pkg.sv - shared SAP datapath constants
package sap_pkg;
   localparam int SAP_WORD_W = 8;
   localparam logic LATCH_RST_VAL = '0;
endpackage

// File: rtl/sap_latch_bit.sv
// rtl/sap_latch_bit.sv - one-bit hold register with transparent bypass mux
module sap_latch_bit
   import sap_pkg::*;
(
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_enable,
   input  logic i_data,
   output logic o_q,
   output logic o_hold
);
   logic hold_q;
   logic hold_d;

   always_comb begin
      hold_d = hold_q;
      if (i_enable) hold_d = i_data;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) hold_q <= LATCH_RST_VAL;
      else          hold_q <= hold_d;
   end

   // Reset forces the output low even while transparent, without waiting for a clock.
   assign o_q    = !i_rst_n ? LATCH_RST_VAL : (i_enable ? i_data : hold_q);
   assign o_hold = hold_q;
endmodule

// File: rtl/sap_d_latch.sv
// rtl/sap_d_latch.sv - WIDTH-bit SAP latch; D_LATCH_CHANGE_FLAG_EN adds o_changed
module sap_d_latch
   import sap_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_enable,
   input  logic [WIDTH-1:0] i_data,
`ifdef D_LATCH_CHANGE_FLAG_EN
   output logic             o_changed,
`endif
   output logic [WIDTH-1:0] o_q,
   output logic [WIDTH-1:0] o_not_q
);
   logic [WIDTH-1:0] q_hold;

   for (genvar g = 0; g < WIDTH; g++) begin : g_bit
      sap_latch_bit u_bit (
         .i_clk    (i_clk),
         .i_rst_n  (i_rst_n),
         .i_enable (i_enable),
         .i_data   (i_data[g]),
         .o_q      (o_q[g]),
         .o_hold   (q_hold[g])
      );
   end

   assign o_not_q = ~o_q;

`ifdef D_LATCH_CHANGE_FLAG_EN
   logic [WIDTH-1:0] hold_d;
   logic             changed_q;
   logic             changed_d;

   // Mirrors the per-bit next-state so the flag lines up with the q_hold update.
   always_comb begin
      hold_d    = i_enable ? i_data : q_hold;
      changed_d = (hold_d != q_hold);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) changed_q <= 1'b0;
      else          changed_q <= changed_d;
   end

   assign o_changed = changed_q;
`endif
endmodule

// File: tb/tb_sap_d_latch.sv
// tb/tb_sap_d_latch.sv - scoreboard bench for sap_d_latch at WIDTH=1 and WIDTH=8
module tb_sap_d_latch;
   logic       clk;
   logic       rst_n;
   logic       en1;
   logic [0:0] d1;
   logic [0:0] q1;
   logic [0:0] nq1;
   logic       en8;
   logic [7:0] d8;
   logic [7:0] q8;
   logic [7:0] nq8;
   int         checks;
   int         failures;
   int         chg_cnt;

   typedef struct {
      string      tag;
      bit         wide;
      logic [7:0] q;
   } exp_t;
   exp_t sb[$];

   sap_d_latch #(.WIDTH(1)) u_dut1 (
      .i_clk    (clk),
      .i_rst_n  (rst_n),
      .i_enable (en1),
      .i_data   (d1),
`ifdef D_LATCH_CHANGE_FLAG_EN
      .o_changed(),
`endif
      .o_q      (q1),
      .o_not_q  (nq1)
   );

`ifdef D_LATCH_CHANGE_FLAG_EN
   logic chg8;
`endif

   sap_d_latch #(.WIDTH(8)) u_dut8 (
      .i_clk    (clk),
      .i_rst_n  (rst_n),
      .i_enable (en8),
      .i_data   (d8),
`ifdef D_LATCH_CHANGE_FLAG_EN
      .o_changed(chg8),
`endif
      .o_q      (q8),
      .o_not_q  (nq8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef D_LATCH_CHANGE_FLAG_EN
   always @(negedge clk) if (rst_n && chg8) chg_cnt++;
`endif

   task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic sb_push(input string tag, input bit wide, input logic [7:0] q);
      exp_t e;
      e.tag  = tag;
      e.wide = wide;
      e.q    = q;
      sb.push_back(e);
   endtask

   task automatic sb_pop();
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL sb_empty observed=0 expected=1");
         return;
      end
      e = sb.pop_front();
      if (e.wide) begin
         check_eq({e.tag, "_q"},  q8,  e.q);
         check_eq({e.tag, "_nq"}, nq8, ~e.q);
      end else begin
         check_eq({e.tag, "_q"},  {7'b0, q1},  {7'b0, e.q[0]});
         check_eq({e.tag, "_nq"}, {7'b0, nq1}, {7'b0, ~e.q[0]});
      end
   endtask

   task automatic expect_now(input string tag, input bit wide, input logic [7:0] q);
      sb_push(tag, wide, q);
      #1;
      sb_pop();
   endtask

   task automatic latch8(input logic [7:0] v);
      @(negedge clk);
      d8  = v;
      en8 = 1'b1;
      @(negedge clk);
      en8 = 1'b0;
      d8  = 8'h00;
      expect_now("w8_hold", 1'b1, v);
   endtask

   initial begin
      checks = 0; failures = 0; chg_cnt = 0;
      rst_n = 1'b0; en1 = 1'b0; d1 = 1'b0; en8 = 1'b0; d8 = 8'h00;
      #2;
      expect_now("in_reset", 1'b0, 8'h00);
      expect_now("in_reset8", 1'b1, 8'h00);
      #7;
      rst_n = 1'b1;
      expect_now("after_reset", 1'b0, 8'h00);

      @(negedge clk);
      d1 = 1'b1;
      repeat (2) @(negedge clk);
      expect_now("hold_ignores_d", 1'b0, 8'h00);

      en1 = 1'b1;
      expect_now("transparent_1", 1'b0, 8'h01);
      @(negedge clk);
      en1 = 1'b0;
      d1  = 1'b0;
      for (int i = 0; i < 3; i++) begin
         expect_now("hold_1", 1'b0, 8'h01);
         @(negedge clk);
      end

      en1 = 1'b1;
      expect_now("transparent_0", 1'b0, 8'h00);
      @(negedge clk);
      d1 = 1'b1;
      expect_now("transparent_1b", 1'b0, 8'h01);
      #2;
      rst_n = 1'b0;
      expect_now("async_reset", 1'b0, 8'h00);
      @(negedge clk);
      en1 = 1'b0;
      rst_n = 1'b1;
      expect_now("hold_cleared", 1'b0, 8'h00);

      latch8(8'hA5);
      latch8(8'hA5);
      latch8(8'h3C);
      expect_now("w8_final", 1'b1, 8'h3C);
      d8 = 8'hFF;
      expect_now("w8_d_ignored", 1'b1, 8'h3C);
      repeat (2) @(negedge clk);
`ifdef D_LATCH_CHANGE_FLAG_EN
      check_eq("chg_pulses", chg_cnt[7:0], 8'd2);
`endif
      check_eq("sb_drained", sb.size() == 0 ? 8'd1 : 8'd0, 8'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
